tick_generator: RTL

Derives all stopwatch timebases from the board clock as single-cycle enable pulses: a 2 Hz tick, a 1 Hz tick phase-locked to it, a display-refresh tick, and an adjust-aware selected tick. It feeds the selected tick to the digit counters, which run at 2 Hz in adjust mode and at 1 Hz otherwise. It also feeds the refresh tick to the seven-segment multiplexer. All logic runs on one clock; no derived clocks leave the block.

---
 rtl/tick_pkg.sv | 12 +
 rtl/tick_divider.sv | 31 +++
 rtl/tick_generator.sv | 102 ++++++++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared constants and helpers for the stopwatch timebase generator.
package tick_pkg;

  localparam int unsigned DEFAULT_CLK_HZ  = 100_000_000;
  localparam int unsigned DEFAULT_FAST_HZ = 500;

  // Counter width for a given divisor, never narrower than one bit.
  function automatic int unsigned divWidth(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with a synchronous restart and a
// combinational terminal-count flag.
module tick_divider
  import tick_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = divWidth(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q + W'(1);
    if (clr || tc) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/tick_generator.sv
// Stopwatch timebases as single-cycle enables: 2 Hz, phase-locked 1 Hz,
// adjust-selected tick and display refresh. Optional blink via STOPWATCH_BLINK_EN.
module tick_generator
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int unsigned FAST_HZ = DEFAULT_FAST_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adj,
  output logic tick_2hz,
  output logic tick_1hz,
  output logic tick_sel,
`ifdef STOPWATCH_BLINK_EN
  output logic tick_fast,
  output logic blink
`else
  output logic tick_fast
`endif
);

  localparam int unsigned HALF_DIV = CLK_HZ / 2;
  localparam int unsigned FAST_DIV = CLK_HZ / FAST_HZ;

  logic halfTc, fastTc;
  logic phase_q, phase_d;
  logic adjMeta_q, adjSync_q;
  logic tick2Hz_q, tick2Hz_d;
  logic tick1Hz_q, tick1Hz_d;
  logic tickSel_q, tickSel_d;
  logic tickFast_q, tickFast_d;

  tick_divider #(.DIV(HALF_DIV)) halfDivider (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tc    (halfTc)
  );

  tick_divider #(.DIV(FAST_DIV)) fastDivider (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tc    (fastTc)
  );

  // clr wins over a coincident terminal count, so that tick is dropped.
  always_comb begin
    phase_d = phase_q;
    if (clr)         phase_d = 1'b0;
    else if (halfTc) phase_d = ~phase_q;
    tick2Hz_d  = halfTc & ~clr;
    tick1Hz_d  = halfTc & phase_q & ~clr;
    tickSel_d  = adjSync_q ? tick2Hz_d : tick1Hz_d;
    tickFast_d = fastTc & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      adjMeta_q  <= 1'b0;
      adjSync_q  <= 1'b0;
      tick2Hz_q  <= 1'b0;
      tick1Hz_q  <= 1'b0;
      tickSel_q  <= 1'b0;
      tickFast_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      adjMeta_q  <= adj;
      adjSync_q  <= adjMeta_q;
      tick2Hz_q  <= tick2Hz_d;
      tick1Hz_q  <= tick1Hz_d;
      tickSel_q  <= tickSel_d;
      tickFast_q <= tickFast_d;
    end
  end

  assign tick_2hz  = tick2Hz_q;
  assign tick_1hz  = tick1Hz_q;
  assign tick_sel  = tickSel_q;
  assign tick_fast = tickFast_q;

`ifdef STOPWATCH_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (clr)         blink_d = 1'b0;
    else if (halfTc) blink_d = ~blink_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end

  assign blink = blink_q;
`endif

endmodule
